// File: rtl/alu_cmd_pkg.sv
// Shared constants for the ALU command executor: command types, ALU opcodes,
// controller state encoding and a small opcode-legality helper.
package alu_cmd_pkg;

  // Command type encoding on cmd_type
  localparam logic CMD_WRITE_IMM = 1'b0;
  localparam logic CMD_ALU_OP    = 1'b1;

  // ALU operation codes on cmd_alu_ctrl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Command sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Opcodes 110 and 111 are reserved; everything up to SLT is implemented
  function automatic logic op_is_legal(input logic [2:0] ctrl);
    return (ctrl <= ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero / signed-overflow / illegal-op flags.
// Overflow is only meaningful for ADD and SUB and reads 0 otherwise.
module alu_core
  import alu_cmd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              sa, sb;
  logic              slt;

  assign sum  = a + b;
  assign diff = a - b;
  assign sa   = a[DATA_W-1];
  assign sb   = b[DATA_W-1];
  assign slt  = ($signed(a) < $signed(b));

  // Operation select and flag generation
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    unique case (ctrl)
      ALU_ADD: begin
        result   = sum;
        // same-sign operands producing a result of the other sign
        overflow = (sa == sb) && (sum[DATA_W-1] != sa);
      end
      ALU_SUB: begin
        result   = diff;
        // differing-sign operands where the result sign departs from A
        overflow = (sa != sb) && (diff[DATA_W-1] != sa);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt};
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_cmd_executor.sv
// Single-command ALU executor: accepts one command over valid/ready, reads
// the local register file, computes (or takes the immediate), writes back and
// returns result and flags over a valid/ready response channel.
// Timeline per command: accept N, EXEC N+1, WB N+2, response from N+3.
module alu_cmd_executor
  import alu_cmd_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 4,
  localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_type,
  input  logic [AW-1:0]     cmd_src1,
  input  logic [AW-1:0]     cmd_src2,
  input  logic [AW-1:0]     cmd_dst,
  input  logic [2:0]        cmd_alu_ctrl,
  input  logic [DATA_W-1:0] cmd_imm,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [AW-1:0]     rsp_dst,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_illegal,
  // debug read port
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t state_q, state_d;

  // captured command
  logic              type_q;
  logic [AW-1:0]     src1_q;
  logic [AW-1:0]     src2_q;
  logic [AW-1:0]     dst_q;
  logic [2:0]        ctrl_q;
  logic [DATA_W-1:0] imm_q;

  // registered result and flags; these drive the response outputs directly
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              ovf_q;
  logic              ill_q;

  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero, alu_ovf, alu_ill;

  logic [DATA_W-1:0] exec_res;
  logic              exec_zero, exec_ovf, exec_ill;

  logic              cmd_fire;
  logic              rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Operand read happens in EXEC, ahead of the WB write, so src == dst is safe
  assign opa = regs[src1_q];
  assign opb = regs[src2_q];

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a        (opa),
    .b        (opb),
    .ctrl     (ctrl_q),
    .result   (alu_res),
    .zero     (alu_zero),
    .overflow (alu_ovf),
    .illegal  (alu_ill)
  );

  // Result select: the immediate path bypasses the ALU and carries no overflow
  always_comb begin
    exec_res  = alu_res;
    exec_zero = alu_zero;
    exec_ovf  = alu_ovf;
    exec_ill  = alu_ill;
    if (type_q == CMD_WRITE_IMM) begin
      exec_res  = imm_q;
      exec_zero = (imm_q == '0);
      exec_ovf  = 1'b0;
      exec_ill  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_fire) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture on accept; fields are ignored while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q <= CMD_WRITE_IMM;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
      ctrl_q <= '0;
      imm_q  <= '0;
    end else if (cmd_fire) begin
      type_q <= cmd_type;
      src1_q <= cmd_src1;
      src2_q <= cmd_src2;
      dst_q  <= cmd_dst;
      ctrl_q <= cmd_alu_ctrl;
      imm_q  <= cmd_imm;
    end
  end

  // Result and flag register, loaded at the end of EXEC and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_q  <= exec_res;
      zero_q <= exec_zero;
      ovf_q  <= exec_ovf;
      ill_q  <= exec_ill;
    end
  end

  // Register file write-back in WB; reset takes priority so a write-back
  // coinciding with reset is dropped, and illegal ops leave the file untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state_q == ST_WB && !ill_q) begin
      regs[dst_q] <= res_q;
    end
  end

  assign rsp_result   = res_q;
  assign rsp_dst      = dst_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign rsp_illegal  = ill_q;

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_cmd_executor.sv
// Scoreboard bench for alu_cmd_executor: the driver pushes hand-computed
// expected responses; a monitor pops and compares on every response handshake.
module tb_alu_cmd_executor;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_type;
  logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [2:0]    cmd_alu_ctrl;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [AW-1:0] rsp_dst;
  logic          rsp_zero, rsp_overflow, rsp_illegal;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [AW-1:0] dst;
    logic          z;
    logic          o;
    logic          i;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_executor #(.DATA_W(DW), .NREG(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_src1     (cmd_src1),
    .cmd_src2     (cmd_src2),
    .cmd_dst      (cmd_dst),
    .cmd_alu_ctrl (cmd_alu_ctrl),
    .cmd_imm      (cmd_imm),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_dst      (rsp_dst),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got result %h dst %0d, expected none", rsp_result, rsp_dst);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result",   64'(rsp_result),   64'(e.res));
          chk("rsp_dst",      64'(rsp_dst),      64'(e.dst));
          chk("rsp_zero",     64'(rsp_zero),     64'(e.z));
          chk("rsp_overflow", 64'(rsp_overflow), 64'(e.o));
          chk("rsp_illegal",  64'(rsp_illegal),  64'(e.i));
        end
      end
    end
  end

  // Issue one command; optionally record its expected response
  task automatic send(input logic t, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic [AW-1:0] d, input logic [2:0] ctrl, input logic [DW-1:0] imm,
                      input logic [DW-1:0] eres, input logic ez, input logic eo, input logic ei,
                      input bit push);
    int n;
    exp_t e;
    @(posedge clk); #1;
    cmd_type = t; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
    cmd_alu_ctrl = ctrl; cmd_imm = imm; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready %b expected 1", cmd_ready);
    end else if (push) begin
      e.res = eres; e.dst = d; e.z = ez; e.o = eo; e.i = ei;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_imm   = 32'hDEADBEEF;
  endtask

  task automatic imm_wr(input logic [AW-1:0] d, input logic [DW-1:0] v);
    send(1'b0, 2'd3, 2'd2, d, 3'b111, v, v, (v == 0), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic alu(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                     input logic [2:0] ctrl, input logic [DW-1:0] eres, input logic eo, input logic ei);
    send(1'b1, s1, s2, d, ctrl, 32'h0, eres, (eres == 0), eo, ei, 1'b1);
  endtask

  // Wait until all expected responses are consumed and the executor is idle
  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic chk_reg(input logic [AW-1:0] a, input logic [DW-1:0] v);
    dbg_addr = a; #1;
    chk($sformatf("dbg_R%0d", a), 64'(dbg_data), 64'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 1'b0; cmd_src1 = '0; cmd_src2 = '0;
    cmd_dst = '0; cmd_alu_ctrl = '0; cmd_imm = '0; rsp_ready = 1'b1; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_flags", 64'({rsp_dst, rsp_zero, rsp_overflow, rsp_illegal}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: immediate writes
    imm_wr(2'd0, 32'h0000000A);
    imm_wr(2'd1, 32'h00000005);
    imm_wr(2'd2, 32'h00000000);
    imm_wr(2'd3, 32'h00000001);
    drain();
    chk_reg(2'd0, 32'h0000000A);
    chk_reg(2'd1, 32'h00000005);
    chk_reg(2'd2, 32'h00000000);
    chk_reg(2'd3, 32'h00000001);

    // 2: dependent ALU chain
    alu(2'd0, 2'd1, 2'd2, 3'b000, 32'h00000005, 1'b0, 1'b0);
    alu(2'd1, 2'd2, 2'd3, 3'b010, 32'h00000000, 1'b0, 1'b0);
    alu(2'd3, 2'd2, 2'd0, 3'b011, 32'h00000005, 1'b0, 1'b0);
    alu(2'd2, 2'd1, 2'd3, 3'b001, 32'hFFFFFFFB, 1'b0, 1'b0);
    drain();
    chk_reg(2'd2, 32'hFFFFFFFB);

    // 3: overflow boundaries and signed compare
    imm_wr(2'd0, 32'h7FFFFFFF);
    imm_wr(2'd1, 32'h00000001);
    alu(2'd2, 2'd0, 2'd1, 3'b000, 32'h80000000, 1'b1, 1'b0);
    imm_wr(2'd0, 32'h80000000);
    alu(2'd3, 2'd0, 2'd1, 3'b001, 32'h7FFFFFFF, 1'b1, 1'b0);
    alu(2'd2, 2'd0, 2'd1, 3'b101, 32'h00000001, 1'b0, 1'b0);
    alu(2'd0, 2'd3, 2'd3, 3'b100, 32'h7FFFFFFF, 1'b0, 1'b0);
    drain();
    chk_reg(2'd3, 32'h7FFFFFFF);
    chk_reg(2'd2, 32'h00000001);

    // 4: response backpressure
    @(posedge clk); #1 rsp_ready = 1'b0;
    imm_wr(2'd1, 32'h00000005);
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    snap = rsp_result;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_result", 64'(rsp_result), 64'h5);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    chk("bp_result_stable", 64'(rsp_result), 64'(snap));
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("bp_next_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("bp_next_rsp_valid", 64'(rsp_valid), 64'd0);
    drain();

    // 5: illegal opcode leaves destination untouched
    alu(2'd1, 2'd0, 2'd2, 3'b110, 32'h00000000, 1'b0, 1'b1);
    drain();
    chk_reg(2'd1, 32'h00000005);

    // 6: reset while in write-back
    send(1'b0, 2'd0, 2'd0, 2'd3, 3'b000, 32'h00001234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("wb_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("wb_rst_after_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("wb_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("wb_rst_rsp_result", 64'(rsp_result), 64'd0);
    for (int r = 0; r < 4; r++) chk_reg(AW'(r), 32'h0);
    repeat (8) @(negedge clk);
    chk("wb_rst_no_rsp", 64'(rsp_valid), 64'd0);
    imm_wr(2'd2, 32'h00000055);
    drain();
    chk_reg(2'd2, 32'h00000055);
    chk_reg(2'd3, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_executor.md
Name: alu_cmd_executor

Overview:
Hardware responder for the register-file/ALU datapath. It accepts one command at a time over a valid/ready interface. A command is either "write immediate to register" or "ALU op: Rdst <- Rsrc1 op Rsrc2". The block sequences the read, compute and write-back steps, then returns result and flags over a valid/ready response channel. It contains its own NREG x DATA_W register file and ALU, and replaces testbench tasks as the driver of the datapath in system-level tests.

Parameters:
DATA_W, 32, datapath and register width
NREG, 4, number of registers; AW = clog2(NREG) is derived, not overridable

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  executor can accept command
cmd_type  in  1  0 = WRITE_IMM, 1 = ALU_OP
cmd_src1  in  AW  operand A register address
cmd_src2  in  AW  operand B register address
cmd_dst  in  AW  destination register address
cmd_alu_ctrl  in  3  ALU operation code
cmd_imm  in  DATA_W  immediate for WRITE_IMM
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  value written to cmd_dst
rsp_dst  out  AW  destination written
rsp_zero  out  1  rsp_result == 0
rsp_overflow  out  1  signed overflow (ADD/SUB only)
rsp_illegal  out  1  unsupported alu_ctrl
dbg_addr  in  AW  debug read address
dbg_data  out  DATA_W  combinational read of register dbg_addr

Behaviour:
- Reset (rst = 1 at a clock edge):
  - All registers clear to 0 and the FSM returns to IDLE.
  - cmd_ready = 0 during reset, 1 in the first cycle after reset.
  - rsp_valid = 0; rsp_result, rsp_dst and all flags = 0.
  - An in-flight command is discarded with no response. A write-back in the same cycle as rst is suppressed.
- FSM states: IDLE, EXEC, WB, RESP.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, capture all cmd_* fields; go to EXEC (cycle N+1).
  - EXEC: read src1/src2 from the register file, compute the ALU result or select the immediate, and register result plus flags. Go to WB.
  - WB: write the result to the register at cmd_dst. Go to RESP; rsp_valid = 1 from cycle N+3.
  - RESP: hold rsp_* stable while rsp_ready = 0. On rsp_ready, go to IDLE; cmd_ready = 1 in the next cycle.
- Minimum command-to-command spacing is 4 cycles. cmd_ready is 0 in EXEC, WB and RESP.
- Commands are fully serialized, so there is no read-after-write hazard. A command whose src equals the previous dst sees the new value.
- src1 == src2 == dst is legal: operands are read in EXEC, before the WB write.
- ALU codes:
  - 000 ADD
  - 001 SUB (A - B)
  - 010 AND
  - 011 XOR
  - 100 OR
  - 101 SLT (signed, result 1/0)
  - 110, 111: result 0, rsp_illegal = 1, and no register write. A response is still issued.
- Arithmetic and flags:
  - All arithmetic is modulo 2^DATA_W.
  - ADD overflow = operands have the same sign and the result has a different sign.
  - SUB overflow = operands have different signs and the result sign differs from A.
  - overflow = 0 for all other operations and for WRITE_IMM.
  - rsp_zero is valid for every command type.
- WRITE_IMM ignores src1, src2 and alu_ctrl; result = cmd_imm.
- dbg_data reflects register contents combinationally. A register written in WB shows its new value from the next cycle.
- cmd_* inputs may change freely while cmd_ready = 0 and are ignored.

Decomposition:
- Package alu_cmd_pkg: cmd_type constants (WRITE_IMM, ALU_OP), the ALU opcode constants above, and the FSM state encoding.
- One sub-module, alu_core: combinational, takes A, B and ctrl; produces result, zero, overflow and illegal.
- The register file and FSM stay in the top module.

Test Plan:
1. WRITE_IMM R0=10, R1=5, R2=0, R3=1 -> four responses with rsp_result = 0000000A, 00000005, 00000000, 00000001. dbg reads match; R2 response has zero = 1.
2. Sequence R0<-R1+R2, R1<-R2&R3, R3<-R2^R0, R2<-R1-R3 from the state of test 1 -> results 00000005, 00000000, 00000005, FFFFFFFB. The last has overflow = 0 and zero = 0.
3. R0 = 7FFFFFFF, R1 = 1, ADD to R2 -> 80000000 with overflow = 1. Then R0 = 80000000, SUB R0-R1 -> 7FFFFFFF with overflow = 1. SLT 80000000 < 1 -> 1.
4. Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_* stable, cmd_ready = 0 throughout. Accept occurs exactly 1 cycle after rsp_ready rises.
5. alu_ctrl = 110 with dst = R1 holding 5 -> rsp_illegal = 1, rsp_result = 0, and R1 still 5.
6. Assert rst in the cycle the FSM is in WB -> no response, all registers 0, cmd_ready = 1 one cycle after rst deasserts.
